// File: rtl/fios_res_pkg.sv
// Shared types for the FIOS result collector: digit width, collector states and digit type.
package fios_res_pkg;

  localparam int DIGIT_W = 17;

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} collect_state_t;

  typedef logic [DIGIT_W-1:0] digit_t;

endpackage

// File: rtl/fios_digit_sub.sv
// One digit of a serial subtractor: computes a + ~b + cin as an 18-bit {cout, d}.
// cout=1 means no borrow out of this digit.
module fios_digit_sub
  import fios_res_pkg::*;
(
  input  logic [DIGIT_W-1:0] a_i,
  input  logic [DIGIT_W-1:0] b_i,
  input  logic               cin_i,
  output logic [DIGIT_W-1:0] d_o,
  output logic               cout_o
);

  logic [DIGIT_W:0] sum;

  assign sum = {1'b0, a_i} + {1'b0, ~b_i} + {{DIGIT_W{1'b0}}, cin_i};
  assign {cout_o, d_o} = sum;

endmodule

// File: rtl/fios_res_collector.sv
// Collects the FIOS multiplier result digits (LSB first) and hands the full word downstream.
// Define FIOS_FINAL_SUB_EN to add the digit-serial final Montgomery subtraction (result >= p ? result - p : result).
module fios_res_collector
  import fios_res_pkg::*;
#(
  parameter int unsigned s = 8
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 res_valid_i,
  input  logic [DIGIT_W-1:0]   res_i,
  input  logic [s*DIGIT_W-1:0] p_i,
  output logic                 busy_o,
  output logic [s*DIGIT_W-1:0] result_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 overflow_o
);

  localparam int W     = s * DIGIT_W;
  localparam int CNT_W = (s > 1) ? $clog2(s) : 1;

  collect_state_t   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     raw_q, raw_d;
  logic [W-1:0]     result_q, result_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             overflow_q, overflow_d;

  logic             accept;
  logic [CNT_W-1:0] idx;
  logic             last;

  // A digit is taken in IDLE/COLLECT, or in HOLD only when the held word is being accepted.
  assign accept = res_valid_i && ((state_q != HOLD) || ready_i);
  assign idx    = (state_q == COLLECT) ? cnt_q : '0;
  assign last   = (idx == CNT_W'(s - 1));

`ifdef FIOS_FINAL_SUB_EN
  logic             carry_q, carry_d;
  logic [W-1:0]     diff_q, diff_d;
  logic [DIGIT_W-1:0] p_digit;
  logic [DIGIT_W-1:0] sub_d;
  logic             sub_cin;
  logic             sub_cout;

  assign p_digit = p_i[idx*DIGIT_W +: DIGIT_W];
  assign sub_cin = (idx == '0) ? 1'b1 : carry_q;

  fios_digit_sub u_digit_sub (
    .a_i    (res_i),
    .b_i    (p_digit),
    .cin_i  (sub_cin),
    .d_o    (sub_d),
    .cout_o (sub_cout)
  );
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    raw_d      = raw_q;
    result_d   = result_q;
    valid_d    = valid_q;
    overflow_d = overflow_q;
`ifdef FIOS_FINAL_SUB_EN
    carry_d    = carry_q;
    diff_d     = diff_q;
`endif

    if (state_q == HOLD && ready_i) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end

    if (state_q == HOLD && res_valid_i && !ready_i) begin
      overflow_d = 1'b1;
    end

    if (accept) begin
      raw_d[idx*DIGIT_W +: DIGIT_W] = res_i;
`ifdef FIOS_FINAL_SUB_EN
      diff_d[idx*DIGIT_W +: DIGIT_W] = sub_d;
      carry_d = sub_cout;
`endif
      if (last) begin
        state_d = HOLD;
        cnt_d   = '0;
        valid_d = 1'b1;
`ifdef FIOS_FINAL_SUB_EN
        // Final carry out of the top digit set means no borrow, i.e. result >= p.
        result_d = sub_cout ? diff_d : raw_d;
`else
        result_d = raw_d;
`endif
      end else begin
        state_d = COLLECT;
        cnt_d   = idx + CNT_W'(1);
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      raw_q      <= '0;
      result_q   <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
`ifdef FIOS_FINAL_SUB_EN
      carry_q    <= 1'b1;
      diff_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      raw_q      <= raw_d;
      result_q   <= result_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
`ifdef FIOS_FINAL_SUB_EN
      carry_q    <= carry_d;
      diff_q     <= diff_d;
`endif
    end
  end

  assign busy_o     = busy_q;
  assign result_o   = result_q;
  assign valid_o    = valid_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_fios_res_collector.sv
// Directed bench for fios_res_collector with s=2 and p = {17'h00001, 17'h00003}.
// Expected results follow FIOS_FINAL_SUB_EN: reduced values when defined, raw digits otherwise.
module tb_fios_res_collector;

  localparam int S  = 2;
  localparam int DW = 17;
  localparam int W  = S * DW;

  localparam logic [W-1:0] P_VAL      = {17'h00001, 17'h00003};
  localparam logic [W-1:0] EXP_NORED  = {17'h00000, 17'h00001};
`ifdef FIOS_FINAL_SUB_EN
  localparam logic [W-1:0] EXP_REDUCE = {17'h00000, 17'h00002};
  localparam logic [W-1:0] EXP_EQUAL  = {17'h00000, 17'h00000};
`else
  localparam logic [W-1:0] EXP_REDUCE = {17'h00001, 17'h00005};
  localparam logic [W-1:0] EXP_EQUAL  = {17'h00001, 17'h00003};
`endif

  logic          clock_i = 1'b0;
  logic          reset_i;
  logic          res_valid_i;
  logic [DW-1:0] res_i;
  logic [W-1:0]  p_i;
  logic          busy_o;
  logic [W-1:0]  result_o;
  logic          valid_o;
  logic          ready_i;
  logic          overflow_o;

  int tests_run = 0;
  int tests_failed = 0;

  fios_res_collector #(.s(S)) dut (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .res_valid_i (res_valid_i),
    .res_i       (res_i),
    .p_i         (p_i),
    .busy_o      (busy_o),
    .result_o    (result_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .overflow_o  (overflow_o)
  );

  always #5 clock_i = ~clock_i;

  // Advance one clock; inputs change 1 time unit after the rising edge, outputs are then stable.
  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic applyStimulus(input logic [DW-1:0] digit);
    res_valid_i = 1'b1;
    res_i       = digit;
    tick();
    res_valid_i = 1'b0;
    res_i       = '0;
  endtask

  task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    reset_i     = 1'b1;
    res_valid_i = 1'b0;
    res_i       = '0;
    p_i         = P_VAL;
    ready_i     = 1'b0;
    tick();
    tick();
    reset_i = 1'b0;
    checkOutput("reset_result", result_o, '0);
    checkOutput("reset_valid", W'(valid_o), '0);
    checkOutput("reset_busy", W'(busy_o), '0);
    checkOutput("reset_overflow", W'(overflow_o), '0);

    // reduce case
    ready_i = 1'b1;
    applyStimulus(17'h00005);
    checkOutput("reduce_busy_mid", W'(busy_o), W'(1));
    checkOutput("reduce_valid_mid", W'(valid_o), '0);
    applyStimulus(17'h00001);
    checkOutput("reduce_valid", W'(valid_o), W'(1));
    checkOutput("reduce_result", result_o, EXP_REDUCE);
    tick();
    checkOutput("reduce_valid_drop", W'(valid_o), '0);
    checkOutput("reduce_busy_drop", W'(busy_o), '0);

    // no-reduce case
    applyStimulus(17'h00001);
    applyStimulus(17'h00000);
    checkOutput("noreduce_valid", W'(valid_o), W'(1));
    checkOutput("noreduce_result", result_o, EXP_NORED);
    tick();

    // equality edge
    applyStimulus(17'h00003);
    applyStimulus(17'h00001);
    checkOutput("equal_result", result_o, EXP_EQUAL);
    tick();
    checkOutput("equal_valid_drop", W'(valid_o), '0);

    // backpressure and overflow
    ready_i = 1'b0;
    applyStimulus(17'h00005);
    applyStimulus(17'h00001);
    checkOutput("bp_valid", W'(valid_o), W'(1));
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("bp_hold_valid", W'(valid_o), W'(1));
      checkOutput("bp_hold_result", result_o, EXP_REDUCE);
    end
    applyStimulus(17'h00007);
    checkOutput("bp_overflow", W'(overflow_o), W'(1));
    checkOutput("bp_result_after_drop", result_o, EXP_REDUCE);
    ready_i = 1'b1;
    tick();
    checkOutput("bp_valid_drop", W'(valid_o), '0);
    checkOutput("bp_busy_drop", W'(busy_o), '0);
    applyStimulus(17'h00001);
    applyStimulus(17'h00000);
    checkOutput("bp_next_result", result_o, EXP_NORED);
    checkOutput("bp_overflow_sticky", W'(overflow_o), W'(1));
    tick();

    // back-to-back: accept and first digit of next result in the same cycle
    ready_i = 1'b0;
    applyStimulus(17'h00005);
    applyStimulus(17'h00001);
    checkOutput("b2b_first_result", result_o, EXP_REDUCE);
    ready_i = 1'b1;
    applyStimulus(17'h00001);
    checkOutput("b2b_valid_gap", W'(valid_o), '0);
    checkOutput("b2b_busy", W'(busy_o), W'(1));
    applyStimulus(17'h00000);
    checkOutput("b2b_valid", W'(valid_o), W'(1));
    checkOutput("b2b_second_result", result_o, EXP_NORED);
    tick();

    // reset mid-operation, then a result with an input gap
    applyStimulus(17'h00005);
    checkOutput("rst_mid_busy", W'(busy_o), W'(1));
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    checkOutput("rst_mid_busy_clr", W'(busy_o), '0);
    checkOutput("rst_mid_valid", W'(valid_o), '0);
    checkOutput("rst_mid_overflow", W'(overflow_o), '0);
    applyStimulus(17'h00005);
    tick();
    tick();
    tick();
    checkOutput("gap_busy", W'(busy_o), W'(1));
    checkOutput("gap_valid", W'(valid_o), '0);
    applyStimulus(17'h00001);
    checkOutput("gap_valid_after", W'(valid_o), W'(1));
    checkOutput("gap_result", result_o, EXP_REDUCE);
    tick();
    checkOutput("final_valid_drop", W'(valid_o), '0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
